// File: rtl/sap_controller.sv
// SAP-1 control sequencer: six-state T-cycle ring plus opcode decode
// driving every load/enable line of the shared-bus datapath.
module sap_controller #(
  parameter bit SKIP_IDLE = 1'b0
) (
  input  logic       clk,
  input  logic       reg_clr,
  input  logic       en,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_en,
  output logic       mar_ld,
  output logic       ram_en,
  output logic       ir_ld,
  output logic       ir_en,
  output logic       acc_ld,
  output logic       acc_en,
  output logic       b_ld,
  output logic       alu_sub,
  output logic       alu_en,
  output logic       out_ld,
  output logic       halted,
  output logic [2:0] SC_cycle
);

  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4,
    T6 = 3'd5
  } t_state_e;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  t_state_e r_state;
  t_state_e w_next;
  logic     r_halted;
  logic     w_halt_set;
  logic     w_act;

  logic w_lda;
  logic w_add;
  logic w_sub;
  logic w_out;
  logic w_hlt;
  logic w_nop;

  assign w_lda = (opcode == OP_LDA);
  assign w_add = (opcode == OP_ADD);
  assign w_sub = (opcode == OP_SUB);
  assign w_out = (opcode == OP_OUT);
  assign w_hlt = (opcode == OP_HLT);
  assign w_nop = ~(w_lda | w_add | w_sub | w_out | w_hlt);

  // Halt freezes the ring regardless of en.
  assign w_act = en & ~r_halted;

  always_ff @(posedge clk or posedge reg_clr) begin
    if (reg_clr) begin
      r_state  <= T1;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_halt_set) begin
        r_halted <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_halt_set = 1'b0;
    if (w_act) begin
      unique case (r_state)
        T1: w_next = T2;
        T2: w_next = T3;
        T3: w_next = T4;
        T4: begin
          if (w_hlt) begin
            w_next     = T1;
            w_halt_set = 1'b1;
          end else if (SKIP_IDLE && (w_out || w_nop)) begin
            w_next = T1;
          end else begin
            w_next = T5;
          end
        end
        T5: begin
          if (SKIP_IDLE && w_lda) begin
            w_next = T1;
          end else begin
            w_next = T6;
          end
        end
        T6:      w_next = T1;
        default: w_next = T1;
      endcase
    end
  end

  always_comb begin
    pc_inc  = 1'b0;
    pc_en   = 1'b0;
    mar_ld  = 1'b0;
    ram_en  = 1'b0;
    ir_ld   = 1'b0;
    ir_en   = 1'b0;
    acc_ld  = 1'b0;
    acc_en  = 1'b0;
    b_ld    = 1'b0;
    alu_sub = 1'b0;
    alu_en  = 1'b0;
    out_ld  = 1'b0;
    if (w_act) begin
      unique case (r_state)
        T1: begin
          pc_en  = 1'b1;
          mar_ld = 1'b1;
        end
        T2: pc_inc = 1'b1;
        T3: begin
          ram_en = 1'b1;
          ir_ld  = 1'b1;
        end
        T4: begin
          if (w_lda || w_add || w_sub) begin
            ir_en  = 1'b1;
            mar_ld = 1'b1;
          end else if (w_out) begin
            acc_en = 1'b1;
            out_ld = 1'b1;
          end
        end
        T5: begin
          if (w_lda) begin
            ram_en = 1'b1;
            acc_ld = 1'b1;
          end else if (w_add || w_sub) begin
            ram_en = 1'b1;
            b_ld   = 1'b1;
          end
        end
        T6: begin
          if (w_add || w_sub) begin
            alu_en  = 1'b1;
            alu_sub = w_sub;
            acc_ld  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign halted   = r_halted;
  assign SC_cycle = r_state;

endmodule

// File: tb/tb_sap_controller.sv
// Directed bench for sap_controller: table vectors for both sequencing
// modes plus hand sequences for halt, en stall and async clear.
module tb_sap_controller;

  localparam logic [11:0] C_PCI = 12'h800;
  localparam logic [11:0] C_PCE = 12'h400;
  localparam logic [11:0] C_MAR = 12'h200;
  localparam logic [11:0] C_RAM = 12'h100;
  localparam logic [11:0] C_IRL = 12'h080;
  localparam logic [11:0] C_IRE = 12'h040;
  localparam logic [11:0] C_ACL = 12'h020;
  localparam logic [11:0] C_ACE = 12'h010;
  localparam logic [11:0] C_BLD = 12'h008;
  localparam logic [11:0] C_SUB = 12'h004;
  localparam logic [11:0] C_ALU = 12'h002;
  localparam logic [11:0] C_OUT = 12'h001;

  typedef struct {
    logic       en;
    logic [3:0] op;
    logic [2:0] sc;
    logic [11:0] ctl;
  } vec_t;

  logic       clk;
  logic       reg_clr;
  logic       en;
  logic [3:0] opcode;

  logic       pci0, pce0, mar0, ram0, irl0, ire0;
  logic       acl0, ace0, bld0, sub0, alu0, out0, hlt0;
  logic [2:0] sc0;
  logic       pci1, pce1, mar1, ram1, irl1, ire1;
  logic       acl1, ace1, bld1, sub1, alu1, out1, hlt1;
  logic [2:0] sc1;

  logic [11:0] ctl0;
  logic [11:0] ctl1;
  assign ctl0 = {pci0, pce0, mar0, ram0, irl0, ire0,
                 acl0, ace0, bld0, sub0, alu0, out0};
  assign ctl1 = {pci1, pce1, mar1, ram1, irl1, ire1,
                 acl1, ace1, bld1, sub1, alu1, out1};

  sap_controller #(.SKIP_IDLE(1'b0)) u_dut0 (
    .clk(clk), .reg_clr(reg_clr), .en(en), .opcode(opcode),
    .pc_inc(pci0), .pc_en(pce0), .mar_ld(mar0), .ram_en(ram0),
    .ir_ld(irl0), .ir_en(ire0), .acc_ld(acl0), .acc_en(ace0),
    .b_ld(bld0), .alu_sub(sub0), .alu_en(alu0), .out_ld(out0),
    .halted(hlt0), .SC_cycle(sc0)
  );

  sap_controller #(.SKIP_IDLE(1'b1)) u_dut1 (
    .clk(clk), .reg_clr(reg_clr), .en(en), .opcode(opcode),
    .pc_inc(pci1), .pc_en(pce1), .mar_ld(mar1), .ram_en(ram1),
    .ir_ld(irl1), .ir_en(ire1), .acc_ld(acl1), .acc_en(ace1),
    .b_ld(bld1), .alu_sub(sub1), .alu_en(alu1), .out_ld(out1),
    .halted(hlt1), .SC_cycle(sc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;
  vec_t tab0[$];
  vec_t tab1[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  name, act, exp, $time);
  endtask

  function automatic vec_t V(input logic e, input logic [3:0] o,
                             input logic [2:0] s, input logic [11:0] c);
    vec_t v;
    v.en = e; v.op = o; v.sc = s; v.ctl = c;
    return v;
  endfunction

  function automatic int drivers(input logic [11:0] c);
    return $countones({c & (C_PCE | C_RAM | C_IRE | C_ACE | C_ALU)});
  endfunction

  task automatic do_reset();
    reg_clr = 1'b1;
    @(posedge clk);
    #1 reg_clr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit which, input int idx);
    en = v.en;
    opcode = v.op;
    #1;
    if (!which) begin
      chk($sformatf("d0[%0d].sc", idx), 32'(sc0), 32'(v.sc));
      chk($sformatf("d0[%0d].ctl", idx), 32'(ctl0), 32'(v.ctl));
      chk($sformatf("d0[%0d].bus", idx), 32'(drivers(ctl0) <= 1), 32'd1);
      chk($sformatf("d0[%0d].hlt", idx), 32'(hlt0), 32'd0);
    end else begin
      chk($sformatf("d1[%0d].sc", idx), 32'(sc1), 32'(v.sc));
      chk($sformatf("d1[%0d].ctl", idx), 32'(ctl1), 32'(v.ctl));
      chk($sformatf("d1[%0d].bus", idx), 32'(drivers(ctl1) <= 1), 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(inout vec_t q[$], input logic [3:0] o);
    q.push_back(V(1, o, 0, C_PCE | C_MAR));
    q.push_back(V(1, o, 1, C_PCI));
    q.push_back(V(1, o, 2, C_RAM | C_IRL));
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reg_clr = 1'b1;
    en = 1'b1;
    opcode = 4'h0;

    // SKIP_IDLE=0 table: LDA, SUB, OUT, NOP, ADD with an en stall in T5
    push_fetch(tab0, 4'h0);
    tab0.push_back(V(1, 4'h0, 3, C_IRE | C_MAR));
    tab0.push_back(V(1, 4'h0, 4, C_RAM | C_ACL));
    tab0.push_back(V(1, 4'h0, 5, 12'h000));
    push_fetch(tab0, 4'h2);
    tab0.push_back(V(1, 4'h2, 3, C_IRE | C_MAR));
    tab0.push_back(V(1, 4'h2, 4, C_RAM | C_BLD));
    tab0.push_back(V(1, 4'h2, 5, C_ALU | C_SUB | C_ACL));
    push_fetch(tab0, 4'hE);
    tab0.push_back(V(1, 4'hE, 3, C_ACE | C_OUT));
    tab0.push_back(V(1, 4'hE, 4, 12'h000));
    tab0.push_back(V(1, 4'hE, 5, 12'h000));
    push_fetch(tab0, 4'h5);
    tab0.push_back(V(1, 4'h5, 3, 12'h000));
    tab0.push_back(V(1, 4'h5, 4, 12'h000));
    tab0.push_back(V(1, 4'h5, 5, 12'h000));
    push_fetch(tab0, 4'h1);
    tab0.push_back(V(1, 4'h1, 3, C_IRE | C_MAR));
    tab0.push_back(V(0, 4'h1, 4, 12'h000));
    tab0.push_back(V(0, 4'h1, 4, 12'h000));
    tab0.push_back(V(0, 4'h1, 4, 12'h000));
    tab0.push_back(V(1, 4'h1, 4, C_RAM | C_BLD));
    tab0.push_back(V(1, 4'h1, 5, C_ALU | C_ACL));
    tab0.push_back(V(1, 4'h0, 0, C_PCE | C_MAR));

    // SKIP_IDLE=1 table: OUT then LDA back to back, ADD, NOP
    push_fetch(tab1, 4'hE);
    tab1.push_back(V(1, 4'hE, 3, C_ACE | C_OUT));
    push_fetch(tab1, 4'h0);
    tab1.push_back(V(1, 4'h0, 3, C_IRE | C_MAR));
    tab1.push_back(V(1, 4'h0, 4, C_RAM | C_ACL));
    push_fetch(tab1, 4'h1);
    tab1.push_back(V(1, 4'h1, 3, C_IRE | C_MAR));
    tab1.push_back(V(1, 4'h1, 4, C_RAM | C_BLD));
    tab1.push_back(V(1, 4'h1, 5, C_ALU | C_ACL));
    push_fetch(tab1, 4'h7);
    tab1.push_back(V(1, 4'h7, 3, 12'h000));
    tab1.push_back(V(1, 4'h0, 0, C_PCE | C_MAR));

    // Reset state, with en high then low
    #2;
    chk("rst.sc", 32'(sc0), 32'd0);
    chk("rst.hlt", 32'(hlt0), 32'd0);
    chk("rst.ctl_en1", 32'(ctl0), 32'(C_PCE | C_MAR));
    en = 1'b0;
    #1;
    chk("rst.ctl_en0", 32'(ctl0), 32'd0);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.hold_sc", 32'(sc0), 32'd0);
    reg_clr = 1'b0;

    for (int i = 0; i < tab0.size(); i++) run_vec(tab0[i], 1'b0, i);

    do_reset();
    for (int i = 0; i < tab1.size(); i++) run_vec(tab1[i], 1'b1, i);

    // HLT: halts after the T4 edge and ignores en until cleared
    do_reset();
    opcode = 4'hF;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    chk("hlt.t4_sc", 32'(sc0), 32'd3);
    chk("hlt.t4_ctl", 32'(ctl0), 32'd0);
    chk("hlt.t4_hlt", 32'(hlt0), 32'd0);
    @(posedge clk);
    #1;
    chk("hlt.set", 32'(hlt0), 32'd1);
    chk("hlt.set_skip", 32'(hlt1), 32'd1);
    for (int i = 0; i < 20; i++) begin
      en = (i % 3 != 1);
      opcode = 4'(i);
      #1;
      chk("hlt.sc", 32'(sc0), 32'd0);
      chk("hlt.ctl", 32'(ctl0), 32'd0);
      chk("hlt.stk", 32'(hlt0), 32'd1);
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    opcode = 4'h0;
    #2 reg_clr = 1'b1;
    #1;
    chk("hlt.clr_hlt", 32'(hlt0), 32'd0);
    chk("hlt.clr_ctl", 32'(ctl0), 32'(C_PCE | C_MAR));
    #9 reg_clr = 1'b0;
    #1;
    chk("hlt.resume_sc", 32'(sc0), 32'd0);
    @(posedge clk);
    #1;
    chk("hlt.resume_t2", 32'(ctl0), 32'(C_PCI));

    // Async clear in the middle of T3
    do_reset();
    opcode = 4'h1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("aclr.t3_sc", 32'(sc0), 32'd2);
    chk("aclr.t3_irl", 32'(irl0), 32'd1);
    #2 reg_clr = 1'b1;
    #1;
    chk("aclr.sc", 32'(sc0), 32'd0);
    chk("aclr.irl", 32'(irl0), 32'd0);
    chk("aclr.sc_skip", 32'(sc1), 32'd0);
    @(posedge clk);
    #1 reg_clr = 1'b0;
    chk("aclr.after", 32'(ctl0), 32'(C_PCE | C_MAR));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
